// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: stream framing widths and FSM state codes.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W          = 16;
    localparam int WORD_W         = 32;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LEN_LO = 3'd1;
    localparam state_t ST_LEN_HI = 3'd2;
    localparam state_t ST_DATA   = 3'd3;
    localparam state_t ST_WRITE  = 3'd4;
    localparam state_t ST_DONE   = 3'd5;
    localparam state_t ST_ERROR  = 3'd6;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs accepted stream bytes little-endian into a 32-bit word and flags the fourth byte.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        rx_byte,
    input  logic              accept,
    input  logic              clear,
    output logic [WORD_W-1:0] word,
    output logic              word_complete
);

    logic [1:0] byte_cnt;

    // Bytes land directly in their lane, so no shifting is needed and the
    // counter wraps to 0 by itself after each complete word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt <= '0;
            word     <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
            word     <= '0;
        end else if (accept) begin
            word[8*byte_cnt +: 8] <= rx_byte;
            byte_cnt              <= byte_cnt + 2'd1;
        end
    end

    assign word_complete = accept && (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed byte image into imem and releases the core from reset once it is complete.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter  int IMEM_DEPTH = 256,
    localparam int ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset_n,
    output logic              load_done,
    output logic              load_error
);

    state_t             state;
    state_t             state_nxt;
    logic [7:0]         len_lo;
    logic [LEN_W-1:0]   n_words;
    logic [LEN_W-1:0]   len_full;
    logic [ADDR_W-1:0]  word_idx;
    logic               core_reset_q;
    logic               rx_accept;
    logic               start_ok;
    logic               len_bad;
    logic               last_word;
    logic               asm_accept;
    logic               asm_complete;
    logic [WORD_W-1:0]  asm_word;

    assign rx_ready   = (state == ST_LEN_LO) || (state == ST_LEN_HI) || (state == ST_DATA);
    assign rx_accept  = rx_valid && rx_ready;
    assign start_ok   = load_start &&
                        ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
    assign len_full   = {rx_data, len_lo};
    assign len_bad    = (len_full == '0) || (len_full > LEN_W'(IMEM_DEPTH));
    assign last_word  = (LEN_W'(word_idx) == (n_words - LEN_W'(1)));
    assign asm_accept = rx_accept && (state == ST_DATA);

    word_assembler u_asm (
        .clk           (clk),
        .reset_n       (reset_n),
        .rx_byte       (rx_data),
        .accept        (asm_accept),
        .clear         (start_ok),
        .word          (asm_word),
        .word_complete (asm_complete)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: if (load_start) state_nxt = ST_LEN_LO;
            ST_LEN_LO: if (rx_accept) state_nxt = ST_LEN_HI;
            ST_LEN_HI: if (rx_accept) state_nxt = len_bad ? ST_ERROR : ST_DATA;
            ST_DATA:   if (asm_complete) state_nxt = ST_WRITE;
            ST_WRITE:  state_nxt = last_word ? ST_DONE : ST_DATA;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            len_lo       <= '0;
            n_words      <= '0;
            word_idx     <= '0;
            core_reset_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            core_reset_q <= (state_nxt == ST_DONE);
            if (start_ok)
                word_idx <= '0;
            if (rx_accept && (state == ST_LEN_LO))
                len_lo <= rx_data;
            if (rx_accept && (state == ST_LEN_HI)) begin
                n_words  <= len_full;
                word_idx <= '0;
            end
            // Index stops at N-1, so it never wraps even when N == IMEM_DEPTH.
            if ((state == ST_WRITE) && !last_word)
                word_idx <= word_idx + ADDR_W'(1);
        end
    end

    assign imem_we      = (state == ST_WRITE);
    assign imem_waddr   = word_idx;
    assign imem_wdata   = asm_word;
    assign core_reset_n = core_reset_q;
    assign load_done    = (state == ST_DONE);
    assign load_error   = (state == ST_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte-level reference model compared every cycle, plus literal checks.
module tb_imem_loader;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          load_start = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          core_reset_n;
    logic          load_done;
    logic          load_error;

    int n_cmp = 0;
    int n_bad = 0;
    int cycle = 0;

    imem_loader #(.IMEM_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_start   (load_start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .core_reset_n (core_reset_n),
        .load_done    (load_done),
        .load_error   (load_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference model: tracks the load as a count of accepted bytes in the current image.
    bit         m_active = 0, m_done = 0, m_err = 0, m_wpend = 0;
    int         m_cnt = 0;
    int         m_n = 0;
    int         m_waddr = 0;
    logic [7:0] m_lo = 0;
    logic [31:0] m_wbuf = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 0; m_done = 0; m_err = 0; m_wpend = 0;
            m_cnt = 0; m_n = 0; m_waddr = 0;
        end else begin
            bit can_start;
            can_start = !m_active;
            if (m_wpend) begin
                m_wpend = 0;
                if (m_waddr == m_n - 1) begin
                    m_active = 0;
                    m_done   = 1;
                end
            end else if (m_active && rx_valid) begin
                m_cnt++;
                if (m_cnt == 1) m_lo = rx_data;
                else if (m_cnt == 2) begin
                    m_n = {rx_data, m_lo};
                    if (m_n == 0 || m_n > DEPTH) begin
                        m_active = 0;
                        m_err    = 1;
                    end
                end else begin
                    int k;
                    k = (m_cnt - 3) % 4;
                    m_wbuf[8*k +: 8] = rx_data;
                    if (k == 3) begin
                        m_wpend = 1;
                        m_waddr = (m_cnt - 3) / 4;
                    end
                end
            end
            if (can_start && load_start) begin
                m_active = 1; m_done = 0; m_err = 0; m_cnt = 0;
            end
        end
    end

    logic [7:0]  log_addr[$];
    logic [31:0] log_data[$];
    int          log_cyc[$];

    always @(negedge clk) begin
        chk("rx_ready", 32'(rx_ready), 32'(m_active && !m_wpend));
        chk("imem_we", 32'(imem_we), 32'(m_wpend));
        chk("load_done", 32'(load_done), 32'(m_done));
        chk("load_error", 32'(load_error), 32'(m_err));
        chk("core_reset_n", 32'(core_reset_n), 32'(m_done));
        if (m_wpend) begin
            chk("imem_waddr", 32'(imem_waddr), 32'(m_waddr));
            chk("imem_wdata", imem_wdata, m_wbuf);
        end
        if (imem_we) begin
            log_addr.push_back(imem_waddr);
            log_data.push_back(imem_wdata);
            log_cyc.push_back(cycle);
        end
    end

    task automatic clear_log();
        log_addr.delete(); log_data.delete(); log_cyc.delete();
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit took;
        int waited;
        if (gap > 0) idle(gap);
        rx_valid = 1'b1;
        rx_data  = b;
        took     = 0;
        waited   = 0;
        while (!took) begin
            took = rx_ready;
            @(posedge clk); #1;
            waited++;
            if (!took && waited > 100) begin
                n_cmp++; n_bad++;
                $display("FAIL byte_timeout: byte %0h not accepted after %0d cycles", b, waited);
                break;
            end
        end
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    task automatic send_list(input logic [7:0] bytes[$], input bit rand_gap);
        foreach (bytes[i]) send_byte(bytes[i], rand_gap ? int'($urandom_range(0, 5)) : 0);
        rx_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        #12;
        chk("rst_rx_ready", 32'(rx_ready), 0);
        chk("rst_we", 32'(imem_we), 0);
        chk("rst_core_reset_n", 32'(core_reset_n), 0);
        chk("rst_wdata", imem_wdata, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle(2);

        // N=2 back-to-back.
        clear_log();
        pulse_start();
        send_list('{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00}, 0);
        idle(3);
        chk("t1_nwrites", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            chk("t1_addr0", 32'(log_addr[0]), 0);
            chk("t1_data0", log_data[0], 32'h00000013);
            chk("t1_addr1", 32'(log_addr[1]), 1);
            chk("t1_data1", log_data[1], 32'h00100093);
            chk("t1_spacing", log_cyc[1] - log_cyc[0], 5);
        end
        chk("t1_done", 32'(load_done), 1);
        chk("t1_core_reset_n", 32'(core_reset_n), 1);

        // N=0 error, then a valid N=1 image.
        clear_log();
        pulse_start();
        send_list('{8'h00, 8'h00}, 0);
        idle(3);
        chk("t2_error", 32'(load_error), 1);
        chk("t2_core_reset_n", 32'(core_reset_n), 0);
        chk("t2_nwrites", log_addr.size(), 0);
        pulse_start();
        send_list('{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12}, 0);
        idle(2);
        chk("t2_nwrites_b", log_addr.size(), 1);
        if (log_addr.size() == 1) chk("t2_data", log_data[0], 32'h12345678);
        chk("t2_done", 32'(load_done), 1);

        // N=257 rejected, N=256 fills all of imem.
        clear_log();
        pulse_start();
        send_list('{8'h01, 8'h01}, 0);
        idle(3);
        chk("t3_error", 32'(load_error), 1);
        chk("t3_nwrites", log_addr.size(), 0);
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        for (int w = 0; w < DEPTH; w++)
            for (int b = 0; b < 4; b++) send_byte(8'(w + b), 0);
        rx_valid = 1'b0;
        idle(3);
        chk("t3_nwrites_b", log_addr.size(), 256);
        if (log_addr.size() == 256) begin
            chk("t3_last_addr", 32'(log_addr[255]), 255);
            chk("t3_last_data", log_data[255], 32'h020100FF);
            chk("t3_first_data", log_data[0], 32'h03020100);
        end
        chk("t3_done", 32'(load_done), 1);

        // N=1 with random valid gaps.
        clear_log();
        pulse_start();
        send_list('{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, 1);
        idle(3);
        chk("t4_nwrites", log_addr.size(), 1);
        if (log_addr.size() == 1) chk("t4_data", log_data[0], 32'hDEADBEEF);

        // Reset after two data bytes, then a clean reload.
        clear_log();
        pulse_start();
        send_list('{8'h01, 8'h00, 8'h11, 8'h22}, 0);
        reset_n = 1'b0;
        #1;
        chk("t5_rx_ready", 32'(rx_ready), 0);
        chk("t5_we", 32'(imem_we), 0);
        chk("t5_waddr", 32'(imem_waddr), 0);
        chk("t5_wdata", imem_wdata, 0);
        chk("t5_done", 32'(load_done), 0);
        chk("t5_error", 32'(load_error), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle(1);
        pulse_start();
        send_list('{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD}, 0);
        idle(2);
        chk("t5_nwrites", log_addr.size(), 1);
        if (log_addr.size() == 1) begin
            chk("t5_addr", 32'(log_addr[0]), 0);
            chk("t5_data", log_data[0], 32'hDDCCBBAA);
        end

        // Bytes offered in DONE are ignored; load_start drops core reset next cycle.
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("t6_ready_in_done", 32'(rx_ready), 0);
        chk("t6_still_done", 32'(load_done), 1);
        rx_valid = 1'b0;
        pulse_start();
        chk("t6_done_low", 32'(load_done), 0);
        chk("t6_core_reset_n_low", 32'(core_reset_n), 0);
        chk("t6_ready_high", 32'(rx_ready), 1);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction memory that the core fetches from. Receives a byte stream over a valid/ready interface and assembles little-endian 32-bit words. Writes those words sequentially into imem through a single write port. Holds the core in reset until a complete, valid image has been written; this replaces simulation-only preloading of imem.

Parameters:
IMEM_DEPTH, 256, number of 32-bit words in imem; legal image length is 1..IMEM_DEPTH.
ADDR_W, $clog2(IMEM_DEPTH), word-address width, derived and not overridden.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
load_start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR.
rx_data  input  8  stream byte.
rx_valid  input  1  rx_data valid.
rx_ready  output  1  loader accepts a byte when rx_valid && rx_ready.
imem_we  output  1  imem write enable, one cycle per word.
imem_waddr  output  ADDR_W  imem word index.
imem_wdata  output  32  imem write data.
core_reset_n  output  1  active-low reset to the core; high only while an image is loaded.
load_done  output  1  high in DONE.
load_error  output  1  high in ERROR.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE, rx_ready 0, imem_we 0, imem_waddr 0, imem_wdata 0, core_reset_n 0, load_done 0, load_error 0, word count 0, byte index 0.
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N×4 data bytes. Each word's bytes are little-endian: byte k goes to wdata[8k+7:8k].
- States:
  - IDLE -> LEN_LO on load_start.
  - LEN_LO -> LEN_HI on byte accept.
  - LEN_HI: on byte accept, N==0 or N>IMEM_DEPTH -> ERROR; otherwise -> DATA, with word index 0.
  - DATA: on 4th byte accept -> WRITE.
  - WRITE: lasts one cycle. Then, if word index == N-1 -> DONE; else word index+1 and -> DATA.
  - DONE -> LEN_LO on load_start.
  - ERROR -> LEN_LO on load_start.
  - load_start is ignored in LEN_LO, LEN_HI, DATA and WRITE.
- rx_ready is a Moore output: 1 in LEN_LO, LEN_HI and DATA; 0 elsewhere. It is never combinationally dependent on rx_valid.
- imem_we = 1 only in WRITE, with imem_waddr = current word index and imem_wdata = assembled word. Each word is written exactly once.
- Latency: a word is written the cycle after its 4th byte is accepted. With rx_valid held high, throughput is 5 cycles per word.
- core_reset_n: registered; 1 exactly while state == DONE. It rises the cycle after the last WRITE and falls the cycle after load_start is taken in DONE.
- load_done = (state==DONE); load_error = (state==ERROR).
- rx_valid gaps: the FSM stalls with no side effects. Bytes offered while rx_ready=0 are not consumed.
- Extra bytes after the image (in DONE or ERROR) are not accepted; rx_ready stays 0.
- Reset mid-load: all outputs return to reset values immediately. Words already written stay in imem. The next load overwrites from address 0.
- Width rules: N is 16 bits and compared against IMEM_DEPTH at 16-bit width. The word index never exceeds N-1, so no wrap.

Decomposition:
- Package imem_loader_pkg: state enum (IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR), BYTES_PER_WORD=4, LEN_W=16, WORD_W=32.
- One sub-module: word_assembler. It holds a 2-bit byte counter and a 32-bit shift/insert register, with inputs byte/accept/clear and outputs word/word_complete. The FSM stays in imem_loader.

Test Plan:
- N=2; bytes 02 00 13 00 00 00 93 00 10 00 streamed back-to-back -> write addr0=0x00000013 then addr1=0x00100093, exactly 2 imem_we pulses 5 cycles apart, then load_done=1 and core_reset_n=1.
- Header 00 00 (N=0) -> load_error=1, core_reset_n=0, no imem_we. Then load_start plus N=1 image 78 56 34 12 -> addr0=0x12345678, DONE.
- IMEM_DEPTH=256, header 01 01 (N=257) -> ERROR, no writes. Header 00 01 (N=256) is accepted, writing addr 0..255 with the last at 255.
- N=1 with random 0–5 cycle rx_valid gaps between bytes -> single write of the correct word, no duplicate or early imem_we.
- reset_n asserted for 1 cycle after 2 of 4 data bytes -> all outputs 0 asynchronously. A new load of N=1 (AA BB CC DD) writes addr0=0xDDCCBBAA, with no stale bytes from the aborted load.
- In DONE, pulse load_start -> core_reset_n=0 and load_done=0 on the next cycle, rx_ready=1. Bytes offered in DONE before load_start are not accepted.
